// File: rtl/bus_arbiter_pkg.sv
// Shared types and limits for the bus command arbiter and its strobe delay units.
package bus_arbiter_pkg;

    localparam int MAX_MASTERS   = 8;
    localparam int MAX_CMD_DELAY = 4;
    localparam int IDX_W         = $clog2(MAX_MASTERS);
    localparam int CNT_W         = $clog2(MAX_CMD_DELAY + 1);

    typedef enum logic [1:0] {
        CPU_OWN,
        HOLD_REQ,
        MASTER_OWN,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/cmd_strobe_delay.sv
// Delays an active-low CPU strobe by CMD_DELAY falling CPU clock edges; the command
// drops back the moment the strobe rises.
module cmd_strobe_delay
    import bus_arbiter_pkg::*;
#(
    parameter int CMD_DELAY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic strobe_n,
    input  logic cpu_clock_negedge,
    output logic active
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CMD_DELAY);

    logic [CNT_W-1:0] count;

    // Saturating count; any high strobe (or loss of bus ownership) restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || strobe_n) begin
            count <= '0;
        end else if (cpu_clock_negedge && (count != TERMINAL)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign active = enable & ~strobe_n & (count == TERMINAL);

endmodule

// File: rtl/bus_command_arbiter.sv
// Arbitrates the system bus between the CPU and round-robin bus masters via HOLD/HLDA.
// Define BUS_COMMAND_ARBITER_ADVANCED_WRITE_EN to make CPU IO writes undelayed.
module bus_command_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int CMD_DELAY   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_clock_posedge,
    input  logic                   cpu_clock_negedge,
    input  logic                   ALE,
    input  logic                   IO_OR_M,
    input  logic                   DT_OR_R,
    input  logic                   RD_N,
    input  logic                   WR_N,
    input  logic                   DEN_N,
    output logic                   HOLD,
    input  logic                   HLDA,
    input  logic [NUM_MASTERS-2:0] m_req,
    output logic [NUM_MASTERS-2:0] m_grant,
    input  logic [NUM_MASTERS-2:0] m_io_or_m,
    input  logic [NUM_MASTERS-2:0] m_rd_n,
    input  logic [NUM_MASTERS-2:0] m_wr_n,
    output logic                   X_IO_OR_M,
    output logic                   R_OR_DT,
    output logic                   MEMR_N,
    output logic                   MEMW_N,
    output logic                   IOR_N,
    output logic                   IOW_N,
    output logic                   IO_E
);

    arb_state_t             state;
    logic                   hold_q;
    logic [NUM_MASTERS-2:0] grant_q;
    logic [NUM_MASTERS-2:0] grant_next;
    logic [IDX_W-1:0]       last_idx;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic                   x_io_q;
    logic                   x_io_now;
    logic                   cpu_own;
    logic                   rd_active;
    logic                   io_wr_ok;
    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] io_ext;
    logic [MAX_MASTERS-1:0] rd_ext;
    logic [MAX_MASTERS-1:0] wr_ext;
    logic                   sel_rd_ok;
    logic                   sel_wr_ok;

    assign req_ext  = MAX_MASTERS'(m_req);
    assign io_ext   = MAX_MASTERS'(m_io_or_m);
    assign rd_ext   = MAX_MASTERS'(m_rd_n);
    assign wr_ext   = MAX_MASTERS'(m_wr_n);
    assign cpu_own  = (state == CPU_OWN);
    assign x_io_now = ALE ? IO_OR_M : x_io_q;

    // Search starts just past the last winner; reset points last_idx at the top index.
    always_comb begin
        winner = last_idx;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_MASTERS - 1; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % (NUM_MASTERS - 1));
            if (!found && req_ext[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS - 1; i++) begin
            grant_next[i] = (winner == IDX_W'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= CPU_OWN;
            hold_q   <= 1'b0;
            grant_q  <= '0;
            last_idx <= IDX_W'(NUM_MASTERS - 2);
            x_io_q   <= 1'b1;
        end else begin
            if (cpu_own && ALE) begin
                x_io_q <= IO_OR_M;
            end
            case (state)
                CPU_OWN: begin
                    if (cpu_clock_posedge && (|m_req)) begin
                        hold_q <= 1'b1;
                        state  <= HOLD_REQ;
                    end
                end
                HOLD_REQ: begin
                    if (!(|m_req)) begin
                        hold_q <= 1'b0;
                        state  <= CPU_OWN;
                    end else if (cpu_clock_posedge && HLDA) begin
                        grant_q  <= grant_next;
                        last_idx <= winner;
                        state    <= MASTER_OWN;
                    end
                end
                // Losing HLDA also ends the tenure so a grant never outlives the acknowledge.
                MASTER_OWN: begin
                    if (!req_ext[last_idx] || !HLDA) begin
                        grant_q <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (cpu_clock_posedge) begin
                        hold_q <= 1'b0;
                    end
                    if (!hold_q && !HLDA) begin
                        state <= CPU_OWN;
                    end
                end
                default: state <= CPU_OWN;
            endcase
        end
    end

    cmd_strobe_delay #(.CMD_DELAY(CMD_DELAY)) u_rd_delay (
        .clock             (clock),
        .reset             (reset),
        .enable            (cpu_own),
        .strobe_n          (RD_N),
        .cpu_clock_negedge (cpu_clock_negedge),
        .active            (rd_active)
    );

`ifdef BUS_COMMAND_ARBITER_ADVANCED_WRITE_EN
    assign io_wr_ok = ~WR_N & RD_N;
`else
    logic wr_active;

    cmd_strobe_delay #(.CMD_DELAY(CMD_DELAY)) u_wr_delay (
        .clock             (clock),
        .reset             (reset),
        .enable            (cpu_own),
        .strobe_n          (WR_N),
        .cpu_clock_negedge (cpu_clock_negedge),
        .active            (wr_active)
    );

    assign io_wr_ok = wr_active & RD_N;
`endif

    assign sel_rd_ok = ~rd_ext[last_idx] & wr_ext[last_idx];
    assign sel_wr_ok = ~wr_ext[last_idx] & rd_ext[last_idx];

    // Commands are gated by reset so they rise immediately without passing through 0.
    always_comb begin
        X_IO_OR_M = 1'b1;
        R_OR_DT   = 1'b1;
        MEMR_N    = 1'b1;
        MEMW_N    = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        if (!reset) begin
            X_IO_OR_M = x_io_q;
            case (state)
                CPU_OWN: begin
                    X_IO_OR_M = x_io_now;
                    R_OR_DT   = ~DT_OR_R;
                    MEMR_N    = ~(rd_active & WR_N & ~x_io_now);
                    IOR_N     = ~(rd_active & WR_N & x_io_now);
                    MEMW_N    = ~(~WR_N & RD_N & ~x_io_now);
                    IOW_N     = ~(io_wr_ok & x_io_now);
                end
                MASTER_OWN: begin
                    X_IO_OR_M = 1'b1;
                    MEMR_N    = ~(sel_rd_ok & ~io_ext[last_idx]);
                    IOR_N     = ~(sel_rd_ok & io_ext[last_idx]);
                    MEMW_N    = ~(sel_wr_ok & ~io_ext[last_idx]);
                    IOW_N     = ~(sel_wr_ok & io_ext[last_idx]);
                end
                default: begin
                end
            endcase
        end
    end

    assign IO_E    = ~((DEN_N | IOR_N) & IOW_N);
    assign HOLD    = hold_q;
    assign m_grant = grant_q;

endmodule
